// File: rtl/dac_extremum_monitor_if.sv
// Sample stream in, indicator/event/capture results out, for the DAC extremum monitor.
// The bench or sequencer side takes the master modport; the monitor takes the slave.
interface dac_extremum_monitor_if #(
    parameter int W  = 10,
    parameter int CW = 8
);
    logic          enable_i;
    logic          clear_i;
    logic          code_valid_i;
    logic [W-1:0]  code_i;
    logic          ext_o;
    logic          ext_oeb_o;
    logic          max_pulse_o;
    logic          min_pulse_o;
    logic [W-1:0]  peak_code_o;
    logic [W-1:0]  trough_code_o;
    logic [CW-1:0] max_cnt_o;
    logic [CW-1:0] min_cnt_o;

    modport master (
        output enable_i, clear_i, code_valid_i, code_i,
        input  ext_o, ext_oeb_o, max_pulse_o, min_pulse_o,
        input  peak_code_o, trough_code_o, max_cnt_o, min_cnt_o
    );

    modport slave (
        input  enable_i, clear_i, code_valid_i, code_i,
        output ext_o, ext_oeb_o, max_pulse_o, min_pulse_o,
        output peak_code_o, trough_code_o, max_cnt_o, min_cnt_o
    );
endinterface

// File: rtl/dac_extremum_monitor.sv
// Tracks the DAC code stream and flags maxima/minima once the signal has
// reversed by at least HYST LSBs; drives a pad indicator plus counters and captures.
module dac_extremum_monitor #(
    parameter int W    = 10,
    parameter int HYST = 4,
    parameter int CW   = 8
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    dac_extremum_monitor_if.slave mon
);

    typedef enum logic [1:0] {IDLE, ACQ, RISE, FALL} state_t;

    // One extra bit so threshold sums near full scale cannot wrap.
    localparam logic [W:0] HYST_X = (W+1)'(HYST);

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] cnt);
        return (&cnt) ? cnt : cnt + 1'b1;
    endfunction

    state_t        state;
    logic [W-1:0]  run_ref, run_max, run_min;
    logic          ext_p0, oeb_p0, max_pulse_p0, min_pulse_p0;
    logic [W-1:0]  peak_p0, trough_p0;
    logic [CW-1:0] max_cnt_p0, min_cnt_p0;

    logic          accept;
    logic [W:0]    code_x, ref_x, max_x, min_x;

    assign accept = mon.enable_i & mon.code_valid_i & ~mon.clear_i;
    assign code_x = {1'b0, mon.code_i};
    assign ref_x  = {1'b0, run_ref};
    assign max_x  = {1'b0, run_max};
    assign min_x  = {1'b0, run_min};

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state        <= IDLE;
            run_ref      <= '0;
            run_max      <= '0;
            run_min      <= '0;
            ext_p0       <= 1'b0;
            oeb_p0       <= 1'b1;
            max_pulse_p0 <= 1'b0;
            min_pulse_p0 <= 1'b0;
            peak_p0      <= '0;
            trough_p0    <= '0;
            max_cnt_p0   <= '0;
            min_cnt_p0   <= '0;
        end else begin
            oeb_p0       <= 1'b0;
            max_pulse_p0 <= 1'b0;
            min_pulse_p0 <= 1'b0;
            if (mon.clear_i) begin
                state      <= IDLE;
                run_ref    <= '0;
                run_max    <= '0;
                run_min    <= '0;
                ext_p0     <= 1'b0;
                peak_p0    <= '0;
                trough_p0  <= '0;
                max_cnt_p0 <= '0;
                min_cnt_p0 <= '0;
            end else if (accept) begin
                case (state)
                    IDLE: begin
                        run_ref <= mon.code_i;
                        state   <= ACQ;
                    end
                    // Reference stays pinned to the first sample until a clear direction emerges.
                    ACQ: begin
                        if (code_x >= ref_x + HYST_X) begin
                            run_max <= mon.code_i;
                            state   <= RISE;
                        end else if (code_x + HYST_X <= ref_x) begin
                            run_min <= mon.code_i;
                            state   <= FALL;
                        end
                    end
                    RISE: begin
                        if (mon.code_i > run_max) begin
                            run_max <= mon.code_i;
                        end else if (code_x + HYST_X <= max_x) begin
                            ext_p0       <= 1'b1;
                            max_pulse_p0 <= 1'b1;
                            peak_p0      <= run_max;
                            max_cnt_p0   <= sat_inc(max_cnt_p0);
                            run_min      <= mon.code_i;
                            state        <= FALL;
                        end
                    end
                    FALL: begin
                        if (mon.code_i < run_min) begin
                            run_min <= mon.code_i;
                        end else if (code_x >= min_x + HYST_X) begin
                            ext_p0       <= 1'b0;
                            min_pulse_p0 <= 1'b1;
                            trough_p0    <= run_min;
                            min_cnt_p0   <= sat_inc(min_cnt_p0);
                            run_max      <= mon.code_i;
                            state        <= RISE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign mon.ext_o         = ext_p0;
    assign mon.ext_oeb_o     = oeb_p0;
    assign mon.max_pulse_o   = max_pulse_p0;
    assign mon.min_pulse_o   = min_pulse_p0;
    assign mon.peak_code_o   = peak_p0;
    assign mon.trough_code_o = trough_p0;
    assign mon.max_cnt_o     = max_cnt_p0;
    assign mon.min_cnt_o     = min_cnt_p0;

endmodule

// File: tb/tb_dac_extremum_monitor.sv
// Directed bench for dac_extremum_monitor: a CW=8 instance plus a CW=2 twin
// fed the same stream so counter saturation can be observed.
module tb_dac_extremum_monitor;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    dac_extremum_monitor_if #(.W(10), .CW(8)) m ();
    dac_extremum_monitor_if #(.W(10), .CW(2)) m2 ();

    assign m2.enable_i     = m.enable_i;
    assign m2.clear_i      = m.clear_i;
    assign m2.code_valid_i = m.code_valid_i;
    assign m2.code_i       = m.code_i;

    dac_extremum_monitor #(.W(10), .HYST(4), .CW(8)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .mon      (m.slave)
    );

    dac_extremum_monitor #(.W(10), .HYST(4), .CW(2)) dut_sat (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .mon      (m2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock with the given inputs, then idle inputs; returns 1 time unit after the edge.
    task automatic feed(input int code, input bit vld = 1'b1, input bit en = 1'b1, input bit clr = 1'b0);
        m.code_i       = 10'(code);
        m.code_valid_i = vld;
        m.enable_i     = en;
        m.clear_i      = clr;
        @(posedge clk);
        #1;
        m.code_valid_i = 1'b0;
        m.enable_i     = 1'b1;
        m.clear_i      = 1'b0;
    endtask

    task automatic apply_reset();
        m.code_valid_i = 1'b0;
        m.enable_i     = 1'b1;
        m.clear_i      = 1'b0;
        m.code_i       = '0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        m.code_valid_i = 1'b1;
        m.code_i = 10'd300;
        @(posedge clk);
        #1;
        n_cmp++; if (m.ext_o !== 1'b0) begin n_fail++; $display("FAIL rst_ext: got %0b want 0", m.ext_o); end
        n_cmp++; if (m.ext_oeb_o !== 1'b1) begin n_fail++; $display("FAIL rst_oeb: got %0b want 1", m.ext_oeb_o); end
        n_cmp++; if ({m.max_pulse_o, m.min_pulse_o} !== 2'b00) begin n_fail++; $display("FAIL rst_pulses: got %b want 00", {m.max_pulse_o, m.min_pulse_o}); end
        n_cmp++; if ({m.peak_code_o, m.trough_code_o} !== 20'd0) begin n_fail++; $display("FAIL rst_caps: got %0d/%0d want 0/0", m.peak_code_o, m.trough_code_o); end
        n_cmp++; if ({m.max_cnt_o, m.min_cnt_o} !== 16'd0) begin n_fail++; $display("FAIL rst_cnts: got %0d/%0d want 0/0", m.max_cnt_o, m.min_cnt_o); end
        m.code_valid_i = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++; if (m.ext_oeb_o !== 1'b0) begin n_fail++; $display("FAIL rst_oeb_release: got %0b want 0", m.ext_oeb_o); end
    endtask

    task automatic test_first_period();
        int stray;
        apply_reset();
        stray = 0;
        for (int c = 0; c <= 1020; c += 10) begin
            feed(c);
            if (m.max_pulse_o || m.min_pulse_o) stray++;
        end
        n_cmp++; if (stray != 0) begin n_fail++; $display("FAIL rise_stray: got %0d pulses want 0", stray); end
        feed(1010);
        n_cmp++; if (m.max_pulse_o !== 1'b1) begin n_fail++; $display("FAIL p1_max_pulse: got %0b want 1", m.max_pulse_o); end
        n_cmp++; if (m.min_pulse_o !== 1'b0) begin n_fail++; $display("FAIL p1_min_quiet: got %0b want 0", m.min_pulse_o); end
        n_cmp++; if (m.peak_code_o !== 10'd1020) begin n_fail++; $display("FAIL p1_peak: got %0d want 1020", m.peak_code_o); end
        n_cmp++; if (m.ext_o !== 1'b1) begin n_fail++; $display("FAIL p1_ext_hi: got %0b want 1", m.ext_o); end
        stray = 0;
        for (int c = 1000; c >= 0; c -= 10) begin
            feed(c);
            if (m.max_pulse_o || m.min_pulse_o) stray++;
        end
        n_cmp++; if (stray != 0) begin n_fail++; $display("FAIL fall_stray: got %0d pulses want 0", stray); end
        feed(10);
        n_cmp++; if (m.min_pulse_o !== 1'b1) begin n_fail++; $display("FAIL p1_min_pulse: got %0b want 1", m.min_pulse_o); end
        n_cmp++; if (m.trough_code_o !== 10'd0) begin n_fail++; $display("FAIL p1_trough: got %0d want 0", m.trough_code_o); end
        n_cmp++; if (m.ext_o !== 1'b0) begin n_fail++; $display("FAIL p1_ext_lo: got %0b want 0", m.ext_o); end
        n_cmp++; if ({m.max_cnt_o, m.min_cnt_o} !== {8'd1, 8'd1}) begin n_fail++; $display("FAIL p1_cnts: got %0d/%0d want 1/1", m.max_cnt_o, m.min_cnt_o); end
    endtask

    task automatic test_three_periods();
        int         n_ev;
        int         both;
        logic [5:0] seq;
        apply_reset();
        n_ev = 0;
        both = 0;
        seq  = '0;
        for (int p = 0; p < 3; p++) begin
            for (int c = 0; c <= 1020; c += 10) begin
                feed(c);
                if (m.max_pulse_o && m.min_pulse_o) both++;
                if (m.max_pulse_o || m.min_pulse_o) begin seq = {seq[4:0], m.ext_o}; n_ev++; end
            end
            for (int c = 1010; c >= 0; c -= 10) begin
                feed(c);
                if (m.max_pulse_o && m.min_pulse_o) both++;
                if (m.max_pulse_o || m.min_pulse_o) begin seq = {seq[4:0], m.ext_o}; n_ev++; end
            end
        end
        feed(10);
        if (m.max_pulse_o || m.min_pulse_o) begin seq = {seq[4:0], m.ext_o}; n_ev++; end
        n_cmp++; if (n_ev != 6) begin n_fail++; $display("FAIL tri3_events: got %0d want 6", n_ev); end
        n_cmp++; if (seq !== 6'b101010) begin n_fail++; $display("FAIL tri3_ext_seq: got %b want 101010", seq); end
        n_cmp++; if (both != 0) begin n_fail++; $display("FAIL tri3_both_pulses: got %0d want 0", both); end
        n_cmp++; if ({m.max_cnt_o, m.min_cnt_o} !== {8'd3, 8'd3}) begin n_fail++; $display("FAIL tri3_cnts: got %0d/%0d want 3/3", m.max_cnt_o, m.min_cnt_o); end
    endtask

    task automatic test_noise();
        int stray;
        apply_reset();
        feed(100);
        feed(500);
        stray = 0;
        feed(497); if (m.max_pulse_o || m.min_pulse_o) stray++;
        feed(499); if (m.max_pulse_o || m.min_pulse_o) stray++;
        feed(497); if (m.max_pulse_o || m.min_pulse_o) stray++;
        n_cmp++; if (stray != 0) begin n_fail++; $display("FAIL noise_stray: got %0d pulses want 0", stray); end
        feed(496);
        n_cmp++; if (m.max_pulse_o !== 1'b1) begin n_fail++; $display("FAIL noise_max_pulse: got %0b want 1", m.max_pulse_o); end
        n_cmp++; if (m.peak_code_o !== 10'd500) begin n_fail++; $display("FAIL noise_peak: got %0d want 500", m.peak_code_o); end
    endtask

    task automatic test_edges_and_gaps();
        int stray;
        apply_reset();
        // 1023+HYST must not wrap: 1020 keeps ACQ, 1019 falls, 1023 completes a MIN.
        feed(1023);
        feed(1020);
        feed(1019);
        feed(1023);
        n_cmp++; if (m.min_pulse_o !== 1'b1) begin n_fail++; $display("FAIL wrap_min_pulse: got %0b want 1", m.min_pulse_o); end
        n_cmp++; if (m.trough_code_o !== 10'd1019) begin n_fail++; $display("FAIL wrap_trough: got %0d want 1019", m.trough_code_o); end
        feed(1019);
        n_cmp++; if (m.max_pulse_o !== 1'b1) begin n_fail++; $display("FAIL top_max_pulse: got %0b want 1", m.max_pulse_o); end
        n_cmp++; if (m.peak_code_o !== 10'd1023) begin n_fail++; $display("FAIL top_peak: got %0d want 1023", m.peak_code_o); end
        stray = 0;
        for (int i = 0; i < 3; i++) begin feed(0, 1'b0, 1'b1); if (m.max_pulse_o || m.min_pulse_o) stray++; end
        for (int i = 0; i < 3; i++) begin feed(0, 1'b1, 1'b0); if (m.max_pulse_o || m.min_pulse_o) stray++; end
        n_cmp++; if (stray != 0) begin n_fail++; $display("FAIL gap_stray: got %0d pulses want 0", stray); end
        n_cmp++; if (m.ext_o !== 1'b1) begin n_fail++; $display("FAIL gap_ext_hold: got %0b want 1", m.ext_o); end
        n_cmp++; if ({m.max_cnt_o, m.min_cnt_o} !== {8'd1, 8'd1}) begin n_fail++; $display("FAIL gap_cnts: got %0d/%0d want 1/1", m.max_cnt_o, m.min_cnt_o); end
        feed(1023);
        n_cmp++; if (m.min_pulse_o !== 1'b1) begin n_fail++; $display("FAIL gap_min_pulse: got %0b want 1", m.min_pulse_o); end
        n_cmp++; if (m.trough_code_o !== 10'd1019) begin n_fail++; $display("FAIL gap_trough: got %0d want 1019", m.trough_code_o); end
        n_cmp++; if (m.min_cnt_o !== 8'd2) begin n_fail++; $display("FAIL gap_min_cnt: got %0d want 2", m.min_cnt_o); end
    endtask

    task automatic test_saturation();
        apply_reset();
        feed(0);
        feed(10);
        for (int k = 1; k <= 5; k++) begin
            feed(0);
            n_cmp++; if (m2.max_pulse_o !== 1'b1) begin n_fail++; $display("FAIL sat_pulse_%0d: got %0b want 1", k, m2.max_pulse_o); end
            feed(10);
        end
        n_cmp++; if (m2.max_cnt_o !== 2'd3) begin n_fail++; $display("FAIL sat_max_cnt_cw2: got %0d want 3", m2.max_cnt_o); end
        n_cmp++; if (m2.min_cnt_o !== 2'd3) begin n_fail++; $display("FAIL sat_min_cnt_cw2: got %0d want 3", m2.min_cnt_o); end
        n_cmp++; if ({m.max_cnt_o, m.min_cnt_o} !== {8'd5, 8'd5}) begin n_fail++; $display("FAIL sat_cnts_cw8: got %0d/%0d want 5/5", m.max_cnt_o, m.min_cnt_o); end
    endtask

    task automatic test_clear();
        // State is RISE with run_max=10: sample 0 alone would be a MAX.
        feed(0, 1'b1, 1'b1, 1'b1);
        n_cmp++; if ({m.max_pulse_o, m.min_pulse_o} !== 2'b00) begin n_fail++; $display("FAIL clr_pulses: got %b want 00", {m.max_pulse_o, m.min_pulse_o}); end
        n_cmp++; if (m.ext_o !== 1'b0) begin n_fail++; $display("FAIL clr_ext: got %0b want 0", m.ext_o); end
        n_cmp++; if ({m.peak_code_o, m.trough_code_o} !== 20'd0) begin n_fail++; $display("FAIL clr_caps: got %0d/%0d want 0/0", m.peak_code_o, m.trough_code_o); end
        n_cmp++; if ({m.max_cnt_o, m.min_cnt_o} !== 16'd0) begin n_fail++; $display("FAIL clr_cnts: got %0d/%0d want 0/0", m.max_cnt_o, m.min_cnt_o); end
        n_cmp++; if (m.ext_oeb_o !== 1'b0) begin n_fail++; $display("FAIL clr_oeb: got %0b want 0", m.ext_oeb_o); end
        feed(500);
        feed(496);
        n_cmp++; if ({m.max_pulse_o, m.min_pulse_o} !== 2'b00) begin n_fail++; $display("FAIL clr_idle_restart: got %b want 00", {m.max_pulse_o, m.min_pulse_o}); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        feed(100);
        feed(200);
        feed(150);
        n_cmp++; if (m.max_pulse_o !== 1'b1) begin n_fail++; $display("FAIL ar_setup_max: got %0b want 1", m.max_pulse_o); end
        #3;
        rst = 1'b1;
        #1;
        n_cmp++; if (m.ext_o !== 1'b0) begin n_fail++; $display("FAIL ar_ext: got %0b want 0", m.ext_o); end
        n_cmp++; if (m.ext_oeb_o !== 1'b1) begin n_fail++; $display("FAIL ar_oeb: got %0b want 1", m.ext_oeb_o); end
        n_cmp++; if (m.peak_code_o !== 10'd0) begin n_fail++; $display("FAIL ar_peak: got %0d want 0", m.peak_code_o); end
        n_cmp++; if (m.max_cnt_o !== 8'd0) begin n_fail++; $display("FAIL ar_max_cnt: got %0d want 0", m.max_cnt_o); end
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++; if (m.ext_oeb_o !== 1'b0) begin n_fail++; $display("FAIL ar_oeb_release: got %0b want 0", m.ext_oeb_o); end
        feed(100);
        feed(110);
        feed(100);
        n_cmp++; if (m.max_pulse_o !== 1'b1) begin n_fail++; $display("FAIL ar_rerun_max: got %0b want 1", m.max_pulse_o); end
        n_cmp++; if (m.peak_code_o !== 10'd110) begin n_fail++; $display("FAIL ar_rerun_peak: got %0d want 110", m.peak_code_o); end
        n_cmp++; if (m.max_cnt_o !== 8'd1) begin n_fail++; $display("FAIL ar_rerun_cnt: got %0d want 1", m.max_cnt_o); end
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        rst = 1'b1;
        m.enable_i = 1'b1;
        m.clear_i = 1'b0;
        m.code_valid_i = 1'b0;
        m.code_i = '0;
        test_reset();
        test_first_period();
        test_three_periods();
        test_noise();
        test_edges_and_gaps();
        test_saturation();
        test_clear();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
